byte_striping: RTL

- Transmit-side counterpart of the byte-joining stage.
- Takes a serial stream of 8-bit bytes and distributes consecutive bytes round-robin over four lanes: byte 0 goes to Lane_0, byte 1 to Lane_1, and so on.
- Each completed group of four is presented in parallel on Lane_0..Lane_3 with a valid/ready handshake, ready for the per-lane serializers.
- A flush request pads a partial group with PAD_BYTE so that no data is stranded.

---
 rtl/stripe_pkg.sv | 18 +
 rtl/stripe_out_reg.sv | 48 ++++
 rtl/byte_striping.sv | 98 +++++++++
 3 files changed

// File: rtl/stripe_pkg.sv
// Shared lane-striping definitions: lane count, K-codes and the fill-state type.
// The byte-joining stage and the deserializer use the same constants.
package stripe_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] PAD_BYTE_DEFAULT = K_PAD;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        ST_FILL,
        ST_FLUSH_WAIT
    } fill_state_t;

endpackage

// File: rtl/stripe_out_reg.sv
// Four-lane output holding register with valid/ready.
// On a load, lanes below i_fill take staged bytes and the rest take PAD_BYTE.
module stripe_out_reg
    import stripe_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] PAD_BYTE = WIDTH'(PAD_BYTE_DEFAULT)
)(
    input  logic                             clk,
    input  logic                             reset_L,
    input  logic                             i_load,
    input  lane_idx_t                        i_fill,
    input  logic                             i_last_en,
    input  logic [WIDTH-1:0]                 i_last_byte,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]  i_staging,
    input  logic                             i_lanes_ready,
    output logic [NUM_LANES-1:0][WIDTH-1:0]  o_lanes,
    output logic                             o_lanes_valid
);

    logic [NUM_LANES-1:0][WIDTH-1:0] w_load_data;

    // A completing group arrives with i_fill == 3 and its last byte still on the input bus.
    always_comb begin
        w_load_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_idx_t'(i) < i_fill)
                w_load_data[lane_idx_t'(i)] = i_staging[lane_idx_t'(i)];
            else if (i_last_en && (i == NUM_LANES - 1))
                w_load_data[lane_idx_t'(i)] = i_last_byte;
            else
                w_load_data[lane_idx_t'(i)] = PAD_BYTE;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            o_lanes       <= '0;
            o_lanes_valid <= 1'b0;
        end else if (i_load) begin
            o_lanes       <= w_load_data;
            o_lanes_valid <= 1'b1;
        end else if (i_lanes_ready) begin
            o_lanes_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_striping.sv
// Distributes a serial byte stream round-robin over four lanes and presents
// each complete (or flush-padded) group with a valid/ready handshake.
module byte_striping
    import stripe_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] PAD_BYTE = WIDTH'(PAD_BYTE_DEFAULT)
)(
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] Lane_0,
    output logic [WIDTH-1:0] Lane_1,
    output logic [WIDTH-1:0] Lane_2,
    output logic [WIDTH-1:0] Lane_3,
    output logic             lanes_valid,
    input  logic             lanes_ready,
    output logic [1:0]       ctr
);

    fill_state_t                      r_state;
    fill_state_t                      w_state_next;
    lane_idx_t                        r_ctr;
    lane_idx_t                        w_ctr_after;
    logic [NUM_LANES-1:0][WIDTH-1:0]  r_staging;
    logic [NUM_LANES-1:0][WIDTH-1:0]  w_lanes;
    logic                             w_lanes_valid;
    logic                             w_out_free;
    logic                             w_accept;
    logic                             w_complete;
    logic                             w_flush_load;

    assign w_out_free   = !w_lanes_valid || lanes_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_complete   = w_accept && (r_ctr == 2'd3);
    assign w_ctr_after  = w_accept ? r_ctr + 2'd1 : r_ctr;
    assign w_flush_load = (r_state == ST_FLUSH_WAIT) && w_out_free;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            r_state <= ST_FILL;
        else
            r_state <= w_state_next;
    end

    // Flush looks at the count after this cycle's byte, so a flush that
    // coincides with a group-completing byte does nothing.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:       if (flush && (w_ctr_after != 2'd0)) w_state_next = ST_FLUSH_WAIT;
            ST_FLUSH_WAIT: if (w_out_free)                     w_state_next = ST_FILL;
            default:       w_state_next = ST_FILL;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_FILL) && ((r_ctr != 2'd3) || w_out_free);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_ctr     <= '0;
            r_staging <= '0;
        end else begin
            r_ctr <= w_flush_load ? 2'd0 : w_ctr_after;
            if (w_accept)
                r_staging[r_ctr] <= in_byte;
        end
    end

    stripe_out_reg #(
        .WIDTH    (WIDTH),
        .PAD_BYTE (PAD_BYTE)
    ) u_out_reg (
        .clk           (clk),
        .reset_L       (reset_L),
        .i_load        (w_complete || w_flush_load),
        .i_fill        (r_ctr),
        .i_last_en     (w_complete),
        .i_last_byte   (in_byte),
        .i_staging     (r_staging),
        .i_lanes_ready (lanes_ready),
        .o_lanes       (w_lanes),
        .o_lanes_valid (w_lanes_valid)
    );

    assign Lane_0      = w_lanes[0];
    assign Lane_1      = w_lanes[1];
    assign Lane_2      = w_lanes[2];
    assign Lane_3      = w_lanes[3];
    assign lanes_valid = w_lanes_valid;
    assign ctr         = r_ctr;

endmodule
